val2_iter_shifter: RTL and testbench
====================================

Name: val2_iter_shifter

Overview:
- Multi-cycle, area-reduced generator for the execute-stage second operand (Val2).
- Replaces the single-cycle barrel shifter with an FSM that moves the operand up to STEP bit positions per clock.
- Sits between ID/EX register and ALU; the hazard/stall unit holds the pipeline while busy=1.
- Covers memory offset, rotated 8-bit immediate, and register LSL/LSR/ASR/ROR by immediate amount.

Parameters:
- WORD_WIDTH, 32, datapath width.
- SHIFTER_OPERAND_WIDTH, 12, shifter operand field width.
- STEP, 1, max bit positions shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort from hazard/branch logic.
- imm  input  1  immediate-operand select.
- is_for_memory  input  1  memory-offset select.
- shifter_operand  input  12  shifter operand field.
- val_Rm  input  32  register operand value.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; val2_out valid and new.
- val2_out  output  32  result register; holds until the next done.

Behaviour:
- Reset: rst_n=0 asynchronously forces state=IDLE, work=0, rem=0, val2_out=0, busy=0, done=0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, flush=0: capture operands at the edge. Priority: is_for_memory, then imm, then register.
  - Memory: work = zero-extended shifter_operand; rem = 0.
  - Immediate: work = zero-extended shifter_operand[7:0]; rem = 2 x shifter_operand[11:8], range 0..30; kind = ROR.
  - Register: work = val_Rm; rem = shifter_operand[11:7]; kind = shifter_operand[6:5].
  - Kind encoding: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Next state is DONE if rem=0, else SHIFT.
- SHIFT: each cycle shift work by n = min(STEP, rem); rem = rem - n.
  - LSL fills with zeros; LSR fills with zeros.
  - ASR replicates bit 31.
  - ROR rotates right.
  - When the new rem = 0, go to DONE.
- val2_out is loaded with the final work value on the edge that enters DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge E0 gives done high in cycle ceil(rem/STEP)+1 after E0. Examples: rem=0 gives 1 cycle; STEP=1 with rem=31 gives 32 cycles.
- Throughput: a new start is accepted no earlier than the cycle after DONE, i.e. at least one idle cycle between operations.
- start while busy=1 is ignored; no queuing.
- Amount 0 returns the captured value unchanged for all kinds. There is no RRX or special 0-amount decoding.
- flush=1 in any state: go to IDLE next edge, no done, val2_out unchanged. flush has priority over start on the same edge and over the DONE transition.
- Internal rem counter is 5 bits. It cannot underflow because n never exceeds rem.
- Outputs are registered only; no combinational input-to-output paths.

Test Plan:
- Immediate, STEP=1: imm=1, shifter_operand=0x2FF -> val2_out=0xF000000F; done exactly 5 cycles after the start edge; busy high for those 5 cycles.
- LSL 31: imm=0, val_Rm=0x00000001, shifter_operand=0xF80 -> val2_out=0x80000000, done at cycle 32 (STEP=1). Repeat with STEP=4 -> done at cycle 9.
- ASR and ROR: val_Rm=0x80000000, shifter_operand=0x240 -> 0xF8000000. val_Rm=0x12345678, shifter_operand=0x460 -> 0x78123456. Also ROR amount 0 (shifter_operand=0x060) -> 0x12345678 with done at cycle 1.
- Memory priority: is_for_memory=1, imm=1, shifter_operand=0xABC -> 0x00000ABC, done at cycle 1, zero SHIFT cycles.
- Busy collision: second start with different operands during SHIFT -> ignored; single done carrying the first result; next start accepted after returning to IDLE.
- Abort: flush asserted at cycle 3 of a 31-step LSL -> no done, busy low next cycle, val2_out keeps its prior value. Same scenario with rst_n pulsed low mid-SHIFT (asynchronous, off clock edge) -> all outputs 0 immediately.

Source files
------------

// File: rtl/val2_iter_shifter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | val2_iter_shifter_if                                               |
// | Request/result bundle between ID/EX stage and the Val2 generator.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface val2_iter_shifter_if #(
   parameter int WORD_WIDTH            = 32,
   parameter int SHIFTER_OPERAND_WIDTH = 12
);
   logic                             start;
   logic                             flush;
   logic                             imm;
   logic                             is_for_memory;
   logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand;
   logic [WORD_WIDTH-1:0]            val_Rm;
   logic                             busy;
   logic                             done;
   logic [WORD_WIDTH-1:0]            val2_out;

   modport master (
      output start, flush, imm, is_for_memory, shifter_operand, val_Rm,
      input  busy, done, val2_out
   );

   modport slave (
      input  start, flush, imm, is_for_memory, shifter_operand, val_Rm,
      output busy, done, val2_out
   );
endinterface
`default_nettype wire

// File: rtl/val2_iter_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | val2_iter_shifter                                                  |
// | Iterative Val2 generator: shifts/rotates up to STEP bits per clock.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module val2_iter_shifter #(
   parameter int WORD_WIDTH            = 32,
   parameter int SHIFTER_OPERAND_WIDTH = 12,
   parameter int STEP                  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   val2_iter_shifter_if.slave  bus
);

   localparam logic [4:0] c_STEP = 5'(STEP);
   localparam logic [1:0] c_LSL  = 2'b00;
   localparam logic [1:0] c_LSR  = 2'b01;
   localparam logic [1:0] c_ASR  = 2'b10;
   localparam logic [1:0] c_ROR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [WORD_WIDTH-1:0] r_work, w_work_nxt;
   logic [WORD_WIDTH-1:0] r_val2, w_val2_nxt;
   logic [4:0]            r_rem, w_rem_nxt;
   logic [1:0]            r_kind, w_kind_nxt;

   logic [WORD_WIDTH-1:0] w_cap_work;
   logic [4:0]            w_cap_rem;
   logic [1:0]            w_cap_kind;
   logic [4:0]            w_n;
   logic [5:0]            w_lrot;
   logic [WORD_WIDTH-1:0] w_shifted;

   // Operand capture: memory offset wins over immediate, which wins over register.
   always_comb begin
      w_cap_work = bus.val_Rm;
      w_cap_rem  = bus.shifter_operand[11:7];
      w_cap_kind = bus.shifter_operand[6:5];
      if (bus.is_for_memory) begin
         w_cap_work = WORD_WIDTH'(bus.shifter_operand);
         w_cap_rem  = 5'd0;
         w_cap_kind = c_LSL;
      end else if (bus.imm) begin
         w_cap_work = WORD_WIDTH'(bus.shifter_operand[7:0]);
         w_cap_rem  = {bus.shifter_operand[11:8], 1'b0};
         w_cap_kind = c_ROR;
      end
   end

   // One iteration moves min(STEP, rem) positions, so rem never underflows.
   assign w_n    = (r_rem < c_STEP) ? r_rem : c_STEP;
   assign w_lrot = 6'(WORD_WIDTH) - {1'b0, w_n};

   always_comb begin
      w_shifted = r_work;
      case (r_kind)
         c_LSL:   w_shifted = r_work << w_n;
         c_LSR:   w_shifted = r_work >> w_n;
         c_ASR:   w_shifted = $signed(r_work) >>> w_n;
         c_ROR:   w_shifted = (r_work >> w_n) | (r_work << w_lrot);
         default: w_shifted = r_work;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_rem_nxt   = r_rem;
      w_kind_nxt  = r_kind;
      w_val2_nxt  = r_val2;
      if (bus.flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  w_work_nxt = w_cap_work;
                  w_rem_nxt  = w_cap_rem;
                  w_kind_nxt = w_cap_kind;
                  if (w_cap_rem == 5'd0) begin
                     w_state_nxt = S_DONE;
                     w_val2_nxt  = w_cap_work;
                  end else begin
                     w_state_nxt = S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               w_work_nxt = w_shifted;
               w_rem_nxt  = r_rem - w_n;
               if (r_rem == w_n) begin
                  w_state_nxt = S_DONE;
                  w_val2_nxt  = w_shifted;
               end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_rem   <= '0;
         r_kind  <= c_LSL;
         r_val2  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_rem   <= w_rem_nxt;
         r_kind  <= w_kind_nxt;
         r_val2  <= w_val2_nxt;
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.val2_out = r_val2;

endmodule
`default_nettype wire

// File: tb/tb_val2_iter_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_val2_iter_shifter                                               |
// | Drives STEP=1 and STEP=4 instances with identical directed vectors.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_val2_iter_shifter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, flush = 1'b0, imm = 1'b0, mem = 1'b0;
   logic [11:0] so    = '0;
   logic [31:0] rm    = '0;

   always #5 clk = ~clk;

   val2_iter_shifter_if #(.WORD_WIDTH(32), .SHIFTER_OPERAND_WIDTH(12)) bif1 ();
   val2_iter_shifter_if #(.WORD_WIDTH(32), .SHIFTER_OPERAND_WIDTH(12)) bif4 ();

   assign bif1.start = start;  assign bif4.start = start;
   assign bif1.flush = flush;  assign bif4.flush = flush;
   assign bif1.imm   = imm;    assign bif4.imm   = imm;
   assign bif1.is_for_memory   = mem; assign bif4.is_for_memory   = mem;
   assign bif1.shifter_operand = so;  assign bif4.shifter_operand = so;
   assign bif1.val_Rm          = rm;  assign bif4.val_Rm          = rm;

   val2_iter_shifter #(.WORD_WIDTH(32), .SHIFTER_OPERAND_WIDTH(12), .STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bif1.slave));
   val2_iter_shifter #(.WORD_WIDTH(32), .SHIFTER_OPERAND_WIDTH(12), .STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bif4.slave));

   logic        w_busy [2];
   logic        w_done [2];
   logic [31:0] w_val  [2];
   assign w_busy[0] = bif1.busy;     assign w_busy[1] = bif4.busy;
   assign w_done[0] = bif1.done;     assign w_done[1] = bif4.done;
   assign w_val[0]  = bif1.val2_out; assign w_val[1]  = bif4.val2_out;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: whole operation at once, with plain arithmetic.
   function automatic logic [4:0] ref_amt(input logic i_imm, input logic i_mem, input logic [11:0] s);
      if (i_mem) return 5'd0;
      if (i_imm) return {s[11:8], 1'b0};
      return s[11:7];
   endfunction

   function automatic logic [31:0] ref_res(input logic i_imm, input logic i_mem,
                                           input logic [11:0] s, input logic [31:0] r);
      logic [63:0] d;
      int          a;
      a = int'(ref_amt(i_imm, i_mem, s));
      if (i_mem) return {20'd0, s};
      if (i_imm) begin
         d = {24'd0, s[7:0], 24'd0, s[7:0]} >> a;
         return d[31:0];
      end
      case (s[6:5])
         2'b00:   return r << a;
         2'b01:   return r >> a;
         2'b10:   return $signed(r) >>> a;
         default: begin
            d = {r, r} >> a;
            return d[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input int amt, input int step);
      return (amt + step - 1) / step + 1;
   endfunction

   function automatic int step_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   // m_cnt: cycles left until (and including) the done cycle; 0 means idle.
   int          m_cnt  [2];
   logic [31:0] m_val  [2];
   logic [31:0] m_pend [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k]  <= 0;
            m_val[k]  <= '0;
            m_pend[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (flush) begin
               m_cnt[k] <= 0;
            end else if (m_cnt[k] == 0) begin
               if (start) begin
                  m_cnt[k]  <= ref_lat(int'(ref_amt(imm, mem, so)), step_of(k));
                  m_pend[k] <= ref_res(imm, mem, so, rm);
                  if (ref_lat(int'(ref_amt(imm, mem, so)), step_of(k)) == 1)
                     m_val[k] <= ref_res(imm, mem, so, rm);
               end
            end else begin
               m_cnt[k] <= m_cnt[k] - 1;
               if (m_cnt[k] == 2) m_val[k] <= m_pend[k];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("busy[%0d]", k), 32'(w_busy[k]), 32'(m_cnt[k] > 0));
         check($sformatf("done[%0d]", k), 32'(w_done[k]), 32'(m_cnt[k] == 1));
         check($sformatf("val2[%0d]", k), w_val[k], m_val[k]);
      end
   end

   task automatic issue(input logic i, input logic m, input logic [11:0] s, input logic [31:0] r);
      @(posedge clk); #1;
      imm = i; mem = m; so = s; rm = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic i, input logic m, input logic [11:0] s,
                         input logic [31:0] r, input logic [31:0] exp, input int l1, input int l4);
      int lat1, lat4;
      lat1 = -1; lat4 = -1;
      issue(i, m, s, r);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (w_done[0] && lat1 < 0) lat1 = c;
         if (w_done[1] && lat4 < 0) lat4 = c;
         if (lat1 >= 0 && lat4 >= 0) break;
      end
      check({nm, " lat1"}, 32'(lat1), 32'(l1));
      check({nm, " lat4"}, 32'(lat4), 32'(l4));
      check({nm, " val1"}, w_val[0], exp);
      check({nm, " val4"}, w_val[1], exp);
   endtask

   initial begin
      int nd1, nd4, ld1, ld4;
      #2;
      check("rst busy", 32'(bif1.busy), 32'd0);
      check("rst done", 32'(bif1.done), 32'd0);
      check("rst val2", bif1.val2_out, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("imm2FF",  1, 0, 12'h2FF, 32'h0,        32'hF000000F, 5,  2);
      run_op("lsl31",   0, 0, 12'hF80, 32'h00000001, 32'h80000000, 32, 9);
      run_op("asr4",    0, 0, 12'h240, 32'h80000000, 32'hF8000000, 5,  2);
      run_op("ror8",    0, 0, 12'h460, 32'h12345678, 32'h78123456, 9,  3);
      run_op("ror0",    0, 0, 12'h060, 32'h12345678, 32'h12345678, 1,  1);
      run_op("memprio", 1, 1, 12'hABC, 32'hFFFFFFFF, 32'h00000ABC, 1,  1);
      run_op("lsr3",    0, 0, 12'h1A0, 32'h80000000, 32'h10000000, 4,  2);
      run_op("imm30",   1, 0, 12'hF01, 32'h0,        32'h00000004, 31, 9);

      // Second start while busy must vanish without a trace.
      nd1 = 0; nd4 = 0; ld1 = -1; ld4 = -1;
      issue(0, 0, 12'hF80, 32'h00000001);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (w_done[0]) begin nd1++; if (ld1 < 0) ld1 = c; end
         if (w_done[1]) begin nd4++; if (ld4 < 0) ld4 = c; end
         if (c == 3) begin so = 12'h060; rm = 32'h12345678; start = 1'b1; end
         if (c == 4) start = 1'b0;
      end
      check("coll ndone1", 32'(nd1), 32'd1);
      check("coll ndone4", 32'(nd4), 32'd1);
      check("coll lat1",   32'(ld1), 32'd32);
      check("coll lat4",   32'(ld4), 32'd9);
      check("coll val1",   w_val[0], 32'h80000000);

      run_op("after", 0, 0, 12'h240, 32'h80000000, 32'hF8000000, 5, 2);

      nd1 = 0; nd4 = 0;
      issue(0, 0, 12'hF80, 32'h00000001);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (w_done[0]) nd1++;
         if (w_done[1]) nd4++;
         if (c == 3) flush = 1'b1;
         if (c == 4) begin
            flush = 1'b0;
            check("flush busy1", 32'(w_busy[0]), 32'd0);
            check("flush busy4", 32'(w_busy[1]), 32'd0);
            check("flush val1",  w_val[0], 32'hF8000000);
         end
      end
      check("flush ndone1", 32'(nd1), 32'd0);
      check("flush ndone4", 32'(nd4), 32'd0);

      issue(0, 0, 12'hF80, 32'h00000001);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst busy1", 32'(w_busy[0]), 32'd0);
      check("arst done1", 32'(w_done[0]), 32'd0);
      check("arst val1",  w_val[0], 32'd0);
      check("arst val4",  w_val[1], 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
